fdtd_ez_sequencer: RTL and testbench

Control stage directly upstream of the FDTD Ez data selector. Over a programmable number of time steps, it sweeps every grid cell with the Ez-update enable and then issues a single source-injection cycle at the source cell. It drives the mutually exclusive `calc_Ez_en` / `calc_src_en` pair and the cell address used by the Ez datapath. It waits out the datapath pipeline latency before injection, so the source value is never overwritten by an in-flight Ez update.

---
 rtl/fdtd_pkg.sv | 16 +
 rtl/fdtd_wait_cnt.sv | 37 +++
 rtl/fdtd_ez_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fdtd_ez_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdtd_pkg.sv
// Shared types and defaults for the FDTD Ez update sequencer.
package fdtd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC_EZ,
    DRAIN_EZ,
    INJECT,
    DRAIN_SRC,
    STEP_END
  } ez_seq_state_t;

  localparam int unsigned DEF_NUM_CELLS  = 200;
  localparam int unsigned DEF_ADDR_WIDTH = $clog2(DEF_NUM_CELLS);

endpackage

// File: rtl/fdtd_wait_cnt.sv
// Loadable down-counter with a zero flag, used to wait out the Ez datapath latency.
module fdtd_wait_cnt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fdtd_ez_sequencer.sv
// Sweeps all Ez cells per time step, waits out the pipeline, then injects the source once.
module fdtd_ez_sequencer
  import fdtd_pkg::*;
#(
  parameter int unsigned NUM_CELLS  = DEF_NUM_CELLS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned STEP_WIDTH = 16,
  parameter int unsigned SRC_CELL   = 100,
  parameter int unsigned PIPE_LAT   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  input  logic [STEP_WIDTH-1:0] num_steps_i,
  input  logic                  ready_i,
  output logic                  calc_Ez_en_o,
  output logic                  calc_src_en_o,
  output logic [ADDR_WIDTH-1:0] cell_addr_o,
  output logic [STEP_WIDTH-1:0] step_cnt_o,
  output logic                  busy_o,
  output logic                  step_done_o,
  output logic                  done_o
);

  localparam int unsigned           WAIT_W    = $clog2(PIPE_LAT + 1);
  // Loaded one below the latency so each drain state lasts exactly PIPE_LAT cycles.
  localparam logic [WAIT_W-1:0]     WAIT_LOAD = WAIT_W'(PIPE_LAT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CELLS - 1);
  localparam logic [ADDR_WIDTH-1:0] SRC_ADDR  = ADDR_WIDTH'(SRC_CELL);

  ez_seq_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STEP_WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d;
  logic                  busy_q, busy_d;
  logic                  step_done_q, step_done_d;
  logic                  done_q, done_d;

  logic wait_load;
  logic wait_dec;
  logic wait_zero;
  logic last_step;

  fdtd_wait_cnt #(
    .WIDTH (WAIT_W)
  ) u_wait_cnt (
    .CLK        (CLK),
    .RST        (RST),
    .load_i     (wait_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (wait_dec),
    .zero_o     (wait_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      step_cnt_q  <= '0;
      steps_q     <= '0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      step_cnt_q  <= step_cnt_d;
      steps_q     <= steps_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      done_q      <= done_d;
    end
  end

  assign last_step = ((step_cnt_q + STEP_WIDTH'(1)) == steps_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    step_cnt_d  = step_cnt_q;
    steps_d     = steps_q;
    busy_d      = busy_q;
    step_done_d = 1'b0;
    done_d      = 1'b0;
    wait_load   = 1'b0;
    wait_dec    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // busy_q is only set in IDLE while a zero-step run signals done.
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (start_i) begin
          steps_d    = num_steps_i;
          addr_d     = '0;
          step_cnt_d = '0;
          busy_d     = 1'b1;
          if (num_steps_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = CALC_EZ;
          end
        end
      end
      CALC_EZ: begin
        if (ready_i) begin
          if (addr_q == LAST_ADDR) begin
            state_d   = DRAIN_EZ;
            wait_load = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN_EZ: begin
        if (wait_zero) begin
          state_d = INJECT;
          addr_d  = SRC_ADDR;
        end else begin
          wait_dec = 1'b1;
        end
      end
      INJECT: begin
        if (ready_i) begin
          state_d   = DRAIN_SRC;
          wait_load = 1'b1;
        end
      end
      DRAIN_SRC: begin
        // Pulses are registered on entry so they coincide with the STEP_END cycle.
        if (wait_zero) begin
          state_d     = STEP_END;
          step_done_d = 1'b1;
          done_d      = last_step;
        end else begin
          wait_dec = 1'b1;
        end
      end
      STEP_END: begin
        if (last_step) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d    = CALC_EZ;
          step_cnt_d = step_cnt_q + STEP_WIDTH'(1);
          addr_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    calc_Ez_en_o  = (state_q == CALC_EZ) && ready_i;
    calc_src_en_o = (state_q == INJECT) && ready_i;
  end

  assign cell_addr_o = addr_q;
  assign step_cnt_o  = step_cnt_q;
  assign busy_o      = busy_q;
  assign step_done_o = step_done_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_fdtd_ez_sequencer.sv
// Randomized bench for fdtd_ez_sequencer against a per-step slot schedule model.
module tb_fdtd_ez_sequencer;

  localparam int N_CELLS = 8;
  localparam int SRC     = 3;
  localparam int LAT     = 2;
  localparam int STEP_W  = 8;
  localparam int CYC_PER_STEP = N_CELLS + LAT + 1 + LAT + 1;

  logic              CLK = 1'b0;
  logic              RST;
  logic              start_i;
  logic [STEP_W-1:0] num_steps_i;
  logic              ready_i;
  logic              calc_Ez_en_o;
  logic              calc_src_en_o;
  logic [2:0]        cell_addr_o;
  logic [STEP_W-1:0] step_cnt_o;
  logic              busy_o;
  logic              step_done_o;
  logic              done_o;

  int n_total = 0;
  int n_bad   = 0;

  fdtd_ez_sequencer #(
    .NUM_CELLS  (N_CELLS),
    .ADDR_WIDTH (3),
    .STEP_WIDTH (STEP_W),
    .SRC_CELL   (SRC),
    .PIPE_LAT   (LAT)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .start_i       (start_i),
    .num_steps_i   (num_steps_i),
    .ready_i       (ready_i),
    .calc_Ez_en_o  (calc_Ez_en_o),
    .calc_src_en_o (calc_src_en_o),
    .cell_addr_o   (cell_addr_o),
    .step_cnt_o    (step_cnt_o),
    .busy_o        (busy_o),
    .step_done_o   (step_done_o),
    .done_o        (done_o)
  );

  always #5 CLK = ~CLK;

  // One slot per expected activity; EZ and SRC slots stall while ready_i is low.
  typedef enum {K_EZ, K_WAIT, K_SRC, K_END} kind_e;
  typedef struct {
    kind_e kind;
    int    addr;
    int    step;
    bit    last;
  } slot_t;

  slot_t sched[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_slot(input kind_e k, input int a, input int s, input bit l);
    slot_t x;
    x.kind = k; x.addr = a; x.step = s; x.last = l;
    sched.push_back(x);
  endfunction

  function automatic void build(input int steps);
    sched.delete();
    for (int s = 0; s < steps; s++) begin
      for (int a = 0; a < N_CELLS; a++) push_slot(K_EZ, a, s, 1'b0);
      for (int w = 0; w < LAT; w++) push_slot(K_WAIT, 0, s, 1'b0);
      push_slot(K_SRC, SRC, s, 1'b0);
      for (int w = 0; w < LAT; w++) push_slot(K_WAIT, 0, s, 1'b0);
      push_slot(K_END, 0, s, s == steps - 1);
    end
  endfunction

  // Entered and left at posedge+1; issues an accepted start pulse.
  task automatic do_start(input int steps);
    start_i     = 1'b1;
    num_steps_i = STEP_W'(steps);
    ready_i     = 1'b1;
    @(negedge CLK);
    check("start_busy", 32'(busy_o), 32'(0));
    check("start_en", 32'({calc_Ez_en_o, calc_src_en_o}), 32'(0));
    @(posedge CLK); #1;
    start_i = 1'b0;
  endtask

  // mode 0: ready high; 1: random ready and start noise; 2: directed backpressure;
  // 3: single busy-time start. Returns early when an EZ slot at abort_step/addr 4 is next.
  task automatic run_sched(input int mode, input int abort_step, input int exp_cycles,
                           output bit aborted);
    slot_t s;
    int cyc = 0;
    int stall_ez = 3;
    int stall_src = 2;
    int last_step = 0;
    bit adv;
    aborted = 1'b0;
    while (sched.size() > 0 && cyc < 2000) begin
      s = sched[0];
      last_step = s.step;
      if (s.kind == K_EZ && s.step == abort_step && s.addr == 4) begin
        aborted = 1'b1;
        break;
      end
      ready_i = 1'b1;
      start_i = 1'b0;
      case (mode)
        1: begin
          ready_i = ($urandom_range(0, 9) < 7);
          start_i = ($urandom_range(0, 3) == 0) || (s.kind == K_END);
          num_steps_i = STEP_W'($urandom_range(0, 9));
        end
        2: begin
          if (s.kind == K_EZ && s.addr == 5 && stall_ez > 0) begin
            ready_i = 1'b0; stall_ez--;
          end
          if (s.kind == K_SRC && stall_src > 0) begin
            ready_i = 1'b0; stall_src--;
          end
        end
        3: begin
          if (s.kind == K_EZ && s.addr == 2) begin
            start_i = 1'b1; num_steps_i = STEP_W'(5);
          end
        end
        default: ;
      endcase
      @(negedge CLK);
      check("excl", 32'(calc_Ez_en_o & calc_src_en_o), 32'(0));
      check("busy", 32'(busy_o), 32'(1));
      check("step_cnt", 32'(step_cnt_o), 32'(s.step));
      adv = 1'b1;
      case (s.kind)
        K_EZ: begin
          check("ez_en", 32'(calc_Ez_en_o), 32'(ready_i));
          check("ez_src_en", 32'(calc_src_en_o), 32'(0));
          check("ez_addr", 32'(cell_addr_o), 32'(s.addr));
          check("ez_pulses", 32'({step_done_o, done_o}), 32'(0));
          adv = ready_i;
        end
        K_WAIT: begin
          check("drain_en", 32'({calc_Ez_en_o, calc_src_en_o}), 32'(0));
          check("drain_pulses", 32'({step_done_o, done_o}), 32'(0));
        end
        K_SRC: begin
          check("src_en", 32'(calc_src_en_o), 32'(ready_i));
          check("src_ez_en", 32'(calc_Ez_en_o), 32'(0));
          check("src_addr", 32'(cell_addr_o), 32'(SRC));
          check("src_pulses", 32'({step_done_o, done_o}), 32'(0));
          adv = ready_i;
        end
        K_END: begin
          check("end_en", 32'({calc_Ez_en_o, calc_src_en_o}), 32'(0));
          check("step_done", 32'(step_done_o), 32'(1));
          check("done", 32'(done_o), 32'(s.last));
        end
        default: ;
      endcase
      if (adv) void'(sched.pop_front());
      cyc++;
      @(posedge CLK); #1;
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    if (cyc >= 2000) check("timeout", 32'(1), 32'(0));
    if (!aborted) begin
      if (exp_cycles >= 0) check("cycles", 32'(cyc), 32'(exp_cycles));
      @(negedge CLK);
      check("idle_busy", 32'(busy_o), 32'(0));
      check("idle_pulses", 32'({step_done_o, done_o}), 32'(0));
      check("idle_en", 32'({calc_Ez_en_o, calc_src_en_o}), 32'(0));
      check("idle_step_hold", 32'(step_cnt_o), 32'(last_step));
      @(posedge CLK); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"}, 32'({calc_Ez_en_o, calc_src_en_o}), 32'(0));
    check({tag, "_addr"}, 32'(cell_addr_o), 32'(0));
    check({tag, "_step"}, 32'(step_cnt_o), 32'(0));
    check({tag, "_flags"}, 32'({busy_o, step_done_o, done_o}), 32'(0));
  endtask

  initial begin
    bit ab;
    int n;
    RST = 1'b1;
    start_i = 1'b0;
    num_steps_i = '0;
    ready_i = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // single step, ready high
    do_start(1); build(1); run_sched(0, -1, CYC_PER_STEP, ab);
    // three steps
    do_start(3); build(3); run_sched(0, -1, 3 * CYC_PER_STEP, ab);
    // backpressure: 3 stalls at address 5, 2 stalls in INJECT
    do_start(1); build(1); run_sched(2, -1, CYC_PER_STEP + 5, ab);

    // zero steps, with a start during the done cycle that must be ignored
    start_i = 1'b1; num_steps_i = '0; ready_i = 1'b1;
    @(negedge CLK);
    check("zero_start_busy", 32'(busy_o), 32'(0));
    @(posedge CLK); #1;
    start_i = 1'b1; num_steps_i = STEP_W'(4);
    @(negedge CLK);
    check("zero_done", 32'(done_o), 32'(1));
    check("zero_en", 32'({calc_Ez_en_o, calc_src_en_o}), 32'(0));
    @(posedge CLK); #1;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("zero_after_done", 32'(done_o), 32'(0));
      check("zero_after_busy", 32'(busy_o), 32'(0));
      check("zero_after_en", 32'({calc_Ez_en_o, calc_src_en_o}), 32'(0));
      @(posedge CLK); #1;
    end

    // reset mid-sweep at address 4 of step index 1
    do_start(3); build(3); run_sched(0, 1, -1, ab);
    check("abort_reached", 32'(ab), 32'(1));
    RST = 1'b1; ready_i = 1'b1;
    @(negedge CLK);
    check("abort_addr", 32'(cell_addr_o), 32'(4));
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      check("midrst_no_done", 32'({busy_o, done_o}), 32'(0));
    end
    @(posedge CLK); #1;
    do_start(1); build(1); run_sched(0, -1, CYC_PER_STEP, ab);

    // start while busy is ignored
    do_start(1); build(1); run_sched(3, -1, CYC_PER_STEP, ab);

    // randomized ready and start noise
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 3);
      do_start(n); build(n); run_sched(1, -1, -1, ab);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
